mips_mc_ctrl: RTL and testbench

Multicycle control unit for the MIPS CPU: a state machine that sequences a shared-memory, multicycle datapath (PC, IR, register file, ALU, ALUOut) through fetch, decode, execute, memory and write-back steps. It sits beside the datapath in `mips`, takes the IR opcode plus a memory ready handshake, and drives every mux select and write enable. It also counts retired instructions for bench monitoring.

---
 rtl/mips_mc_pkg.sv | 47 ++++
 rtl/mips_mc_outdec.sv | 71 +++++++
 rtl/mips_mc_ctrl.sv | 111 +++++++++++
 tb/tb_mips_mc_ctrl.sv | 120 ++++++++++++
 4 files changed

// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
package mips_mc_pkg;

  localparam int unsigned OP_W = 6;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXEC, ALUWB, BRANCH, JUMP, ADDIEX, ADDIWB
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_4       = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/mips_mc_outdec.sv
// Control-word decode from the current FSM state, qualified by run/mem_ready in FETCH.
module mips_mc_outdec
  import mips_mc_pkg::*;
(
  input  state_t state,
  input  logic   run,
  input  logic   mem_ready,
  output ctrl_t  ctrl_c
);

  always_comb begin
    ctrl_c = '0;
    case (state)
      FETCH: begin
        ctrl_c.mem_read  = run;
        ctrl_c.alu_src_b = SRCB_4;
        ctrl_c.alu_op    = ALU_ADD;
        ctrl_c.pc_source = PCSRC_ALU;
        ctrl_c.ir_write  = run && mem_ready;
        ctrl_c.pc_write  = run && mem_ready;
      end
      DECODE: begin
        // Branch target precomputed into ALUOut while the opcode decodes.
        ctrl_c.alu_src_b = SRCB_IMM_SH2;
        ctrl_c.alu_op    = ALU_ADD;
      end
      MEMADR, ADDIEX: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_IMM;
        ctrl_c.alu_op    = ALU_ADD;
      end
      MEMRD: begin
        ctrl_c.mem_read = 1'b1;
        ctrl_c.iord     = 1'b1;
      end
      MEMWB: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.mem_to_reg = 1'b1;
      end
      MEMWR: begin
        ctrl_c.mem_write = 1'b1;
        ctrl_c.iord      = 1'b1;
      end
      EXEC: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_B;
        ctrl_c.alu_op    = ALU_FUNCT;
      end
      ALUWB: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.reg_dst   = 1'b1;
      end
      BRANCH: begin
        ctrl_c.alu_src_a     = 1'b1;
        ctrl_c.alu_src_b     = SRCB_B;
        ctrl_c.alu_op        = ALU_SUB;
        ctrl_c.pc_write_cond = 1'b1;
        ctrl_c.pc_source     = PCSRC_ALUOUT;
      end
      JUMP: begin
        ctrl_c.pc_write  = 1'b1;
        ctrl_c.pc_source = PCSRC_JUMP;
      end
      ADDIWB: begin
        ctrl_c.reg_write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM: state register, next-state logic and retired-instruction counter.
module mips_mc_ctrl
  import mips_mc_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [OP_W-1:0]  opcode,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             retire,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  state_t           state_q, state_d;
  logic             is_sw_q;
  logic [CNT_W-1:0] count_q;
  logic             retire_c, illegal_c;
  ctrl_t            ctrl_c, ctrl;

  mips_mc_outdec u_outdec (
    .state     (state_q),
    .run       (run),
    .mem_ready (mem_ready),
    .ctrl_c    (ctrl_c)
  );

  // lw/sw choice is latched in DECODE so the opcode is only looked at there.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      is_sw_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) is_sw_q <= (opcode == OP_SW);
      if (retire_c) count_q <= count_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    retire_c  = 1'b0;
    illegal_c = 1'b0;
    case (state_q)
      FETCH:  if (run && mem_ready) state_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXEC;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          OP_ADDI:      state_d = ADDIEX;
          default: begin
            state_d   = FETCH;
            illegal_c = 1'b1;
          end
        endcase
      end
      MEMADR: state_d = is_sw_q ? MEMWR : MEMRD;
      MEMRD:  if (mem_ready) state_d = MEMWB;
      MEMWR: begin
        if (mem_ready) begin
          retire_c = 1'b1;
          state_d  = FETCH;
        end
      end
      EXEC:   state_d = ALUWB;
      ADDIEX: state_d = ADDIWB;
      MEMWB, ALUWB, BRANCH, JUMP, ADDIWB: begin
        retire_c = 1'b1;
        state_d  = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  assign ctrl          = rst ? '0 : ctrl_c;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign iord          = ctrl.iord;
  assign ir_write      = ctrl.ir_write;
  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign reg_write     = ctrl.reg_write;
  assign reg_dst       = ctrl.reg_dst;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign retire        = !rst && retire_c;
  assign illegal_op    = !rst && illegal_c;
  assign instr_count   = rst ? '0 : count_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Table-driven cycle-by-cycle check of the multicycle MIPS control unit.
module tb_mips_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst, run, mem_ready;
  logic [5:0]  opcode;
  logic        mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond;
  logic        reg_write, reg_dst, mem_to_reg, alu_src_a, retire, illegal_op;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [31:0] instr_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mips_mc_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .retire(retire), .illegal_op(illegal_op), .instr_count(instr_count)
  );

  typedef struct {
    logic        rst, run, mr;
    logic [5:0]  op;
    logic [17:0] exp;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [17:0] w(input logic mr, mw, io, irw, pcw, pcc, rw, rd, m2r, sa,
                                    input logic [1:0] sb, aop, ps, input logic ret, ill);
    return {mr, mw, io, irw, pcw, pcc, rw, rd, m2r, sa, sb, aop, ps, ret, ill};
  endfunction

  task automatic add(input logic r, ru, m, input logic [5:0] op, input logic [17:0] e,
                     input logic [31:0] c);
    vec_t v;
    v.rst = r; v.run = ru; v.mr = m; v.op = op; v.exp = e; v.cnt = c;
    vecs.push_back(v);
  endtask

  logic [17:0] Z, F1, F0, FI, DEC, DECI, MADR, MRD, MWB, MWW, MWD, EX, AWB, BR, JMP, AIWB;
  logic [5:0]  R, LW, SW, BEQ, J, ADDI, XX, ILL;
  logic [17:0] got;

  initial begin
    R = 6'b000000; LW = 6'b100011; SW = 6'b101011; BEQ = 6'b000100;
    J = 6'b000010; ADDI = 6'b001000; XX = 6'b111110; ILL = 6'b111111;

    Z    = '0;
    F1   = w(1,0,0,1,1,0,0,0,0,0, 2'b01, 2'b00, 2'b00, 0,0);
    F0   = w(1,0,0,0,0,0,0,0,0,0, 2'b01, 2'b00, 2'b00, 0,0);
    FI   = w(0,0,0,0,0,0,0,0,0,0, 2'b01, 2'b00, 2'b00, 0,0);
    DEC  = w(0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00, 0,0);
    DECI = w(0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00, 0,1);
    MADR = w(0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00, 0,0);
    MRD  = w(1,0,1,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0,0);
    MWB  = w(0,0,0,0,0,0,1,0,1,0, 2'b00, 2'b00, 2'b00, 1,0);
    MWW  = w(0,1,1,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0,0);
    MWD  = w(0,1,1,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 1,0);
    EX   = w(0,0,0,0,0,0,0,0,0,1, 2'b00, 2'b10, 2'b00, 0,0);
    AWB  = w(0,0,0,0,0,0,1,1,0,0, 2'b00, 2'b00, 2'b00, 1,0);
    BR   = w(0,0,0,0,0,1,0,0,0,1, 2'b00, 2'b01, 2'b01, 1,0);
    JMP  = w(0,0,0,0,1,0,0,0,0,0, 2'b00, 2'b00, 2'b10, 1,0);
    AIWB = w(0,0,0,0,0,0,1,0,0,0, 2'b00, 2'b00, 2'b00, 1,0);

    // reset held; outputs all zero
    add(1,1,1,XX,Z,0);   add(1,1,1,XX,Z,0);
    // R, lw, sw, beq, j, addi back to back
    add(0,1,1,XX,F1,0);  add(0,1,1,R,DEC,0);   add(0,1,1,XX,EX,0);   add(0,1,1,XX,AWB,0);
    add(0,1,1,XX,F1,1);  add(0,1,1,LW,DEC,1);  add(0,1,1,XX,MADR,1); add(0,1,1,XX,MRD,1);
    add(0,1,1,XX,MWB,1);
    add(0,1,1,XX,F1,2);  add(0,1,1,SW,DEC,2);  add(0,1,1,XX,MADR,2); add(0,1,1,XX,MWD,2);
    add(0,1,1,XX,F1,3);  add(0,1,1,BEQ,DEC,3); add(0,1,1,XX,BR,3);
    add(0,1,1,XX,F1,4);  add(0,1,1,J,DEC,4);   add(0,1,1,XX,JMP,4);
    add(0,1,1,XX,F1,5);  add(0,1,1,ADDI,DEC,5); add(0,1,1,XX,MADR,5); add(0,1,1,XX,AIWB,5);
    // lw with three wait cycles in MEMRD
    add(0,1,1,XX,F1,6);  add(0,1,1,LW,DEC,6);  add(0,1,1,XX,MADR,6);
    add(0,1,0,XX,MRD,6); add(0,1,0,XX,MRD,6);  add(0,1,0,XX,MRD,6);  add(0,1,1,XX,MRD,6);
    add(0,1,1,XX,MWB,6);
    // illegal opcode: no retire, count unchanged
    add(0,1,1,XX,F1,7);  add(0,1,1,ILL,DECI,7);
    // run dropped during EXEC: instruction completes, then FETCH idles
    add(0,1,1,XX,F1,7);  add(0,1,1,R,DEC,7);   add(0,0,1,XX,EX,7);   add(0,0,1,XX,AWB,7);
    add(0,0,1,XX,FI,8);  add(0,0,1,XX,FI,8);   add(0,0,0,XX,FI,8);
    // fetch wait, then reset while sw waits in MEMWR
    add(0,1,0,XX,F0,8);  add(0,1,1,XX,F1,8);   add(0,1,1,SW,DEC,8);  add(0,1,1,XX,MADR,8);
    add(0,1,0,XX,MWW,8); add(0,1,0,XX,MWW,8);  add(1,1,0,XX,Z,0);
    add(0,1,0,XX,F0,0);  add(0,1,0,XX,F0,0);

    rst = 1'b1; run = 1'b1; mem_ready = 1'b1; opcode = XX;
    @(posedge clk); #1;
    foreach (vecs[i]) begin
      rst = vecs[i].rst; run = vecs[i].run; mem_ready = vecs[i].mr; opcode = vecs[i].op;
      @(negedge clk);
      got = {mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond, reg_write,
             reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, retire, illegal_op};
      n_checks++;
      if (got !== vecs[i].exp) begin
        n_fail++;
        $display("FAIL row %0d ctrl: got %b expected %b", i, got, vecs[i].exp);
      end
      n_checks++;
      if (instr_count !== vecs[i].cnt) begin
        n_fail++;
        $display("FAIL row %0d instr_count: got %0d expected %0d", i, instr_count, vecs[i].cnt);
      end
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
